// File: rtl/dvp_tx_pkg.sv
// Shared types and constants for the DVP camera-side transmitter:
// FSM states, pattern_sel codes and the RGB565 colour-bar palette.
package dvp_tx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StBporch,
    StActive,
    StFporch
  } state_e;

  localparam logic [1:0] PatBars  = 2'd0;
  localparam logic [1:0] PatGrad  = 2'd1;
  localparam logic [1:0] PatSolid = 2'd2;
  localparam logic [1:0] PatCheck = 2'd3;

  function automatic logic [15:0] bar_colour(input logic [2:0] idx);
    logic [15:0] c;
    unique case (idx)
      3'd0:    c = 16'hFFFF;
      3'd1:    c = 16'hFFE0;
      3'd2:    c = 16'h07FF;
      3'd3:    c = 16'h07E0;
      3'd4:    c = 16'hF81F;
      3'd5:    c = 16'hF800;
      3'd6:    c = 16'h001F;
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/dvp_tx_pattern_gen.sv
// Combinational test-pattern source: maps an active pixel position to an RGB565 value.
module dvp_tx_pattern_gen (
  input  logic [12:0] x,
  input  logic [12:0] y,
  input  logic [1:0]  pattern,
  input  logic [15:0] solid_rgb,
  input  logic [12:0] bar_width,
  output logic [15:0] pixel
);
  import dvp_tx_pkg::*;

  logic [2:0] bar_idx;

  // Bar index = x / bar_width saturated at 7, via threshold compares instead of a divider.
  always_comb begin
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if ({3'b000, x} >= 16'(k) * {3'b000, bar_width}) begin
        bar_idx = 3'(k);
      end
    end
  end

  always_comb begin
    pixel = 16'h0000;
    unique case (pattern)
      PatBars:  pixel = bar_colour(bar_idx);
      PatGrad:  pixel = {y[7:0], x[7:0]};
      PatSolid: pixel = solid_rgb;
      PatCheck: pixel = (x[3] ^ y[3]) ? 16'hFFFF : 16'h0000;
      default:  pixel = 16'h0000;
    endcase
  end

endmodule

// File: rtl/dvp_cam_tx.sv
// DVP camera-side transmitter emulating an OV5640 in RGB565 mode (two bytes per pixel).
// Optional macro DVP_TX_FRAME_TAG_EN: pixel (0,0) of each frame carries frame_cnt.
module dvp_cam_tx #(
  parameter int unsigned VS_LINES = 1,
  parameter int unsigned V_START  = 2,
  parameter int unsigned H_START  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_en,
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] solid_rgb,
  input  logic [12:0] cmos_h_pixel,
  input  logic [12:0] cmos_v_pixel,
  input  logic [12:0] total_h_pixel,
  input  logic [12:0] total_v_pixel,
  output logic        cam_vsync,
  output logic        cam_href,
  output logic [7:0]  cam_data,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic        busy,
  output logic        cfg_err
);
  import dvp_tx_pkg::*;

  localparam logic [12:0] VsLines = 13'(VS_LINES);
  localparam logic [12:0] VStart  = 13'(V_START);
  localparam logic [12:0] HStart  = 13'(H_START);
  localparam logic [13:0] HrefLo  = 14'(2 * H_START);

  state_e      state_q, state_d;
  logic [13:0] bx_q, bx_d;
  logic [12:0] ly_q, ly_d, ly_nx;
  logic [12:0] h_act_q, v_act_q, h_tot_q, v_tot_q;
  logic [1:0]  pat_q;
  logic [15:0] solid_q;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        cfg_err_q, cfg_err_d;
  logic        vsync_q, vsync_d, href_q, href_d, done_q, done_d;
  logic [7:0]  data_q, data_d;
  logic        cfg_ok, line_end, frame_end, start, latch;
  logic [12:0] px, py, bar_w;
  logic [15:0] pix, pix_out;

  always_comb begin
    cfg_ok = (cmos_h_pixel != 13'd0) && (cmos_v_pixel != 13'd0) &&
             ({1'b0, total_h_pixel} >= {1'b0, HStart} + {1'b0, cmos_h_pixel}) &&
             ({1'b0, total_v_pixel} >= {1'b0, VStart} + {1'b0, cmos_v_pixel});
    line_end  = bx_q == ({h_tot_q, 1'b0} - 14'd1);
    frame_end = line_end && (ly_q == v_tot_q - 13'd1);
    ly_nx     = ly_q + 13'd1;

    state_d     = state_q;
    bx_d        = bx_q;
    ly_d        = ly_q;
    frame_cnt_d = frame_cnt_q;
    cfg_err_d   = cfg_err_q;
    start       = 1'b0;
    latch       = 1'b0;

    if (state_q == StIdle) begin
      start = tx_en;
    end else if (frame_end) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
      state_d     = StIdle;
      start       = tx_en;
    end else if (line_end) begin
      bx_d = 14'd0;
      ly_d = ly_nx;
      if (ly_nx < VsLines) begin
        state_d = StSync;
      end else if (ly_nx < VStart) begin
        state_d = StBporch;
      end else if ({1'b0, ly_nx} < {1'b0, VStart} + {1'b0, v_act_q}) begin
        state_d = StActive;
      end else begin
        state_d = StFporch;
      end
    end else begin
      bx_d = bx_q + 14'd1;
    end

    // Covers both the first start from IDLE and the back-to-back restart at frame end.
    if (start) begin
      if (cfg_ok) begin
        latch     = 1'b1;
        state_d   = StSync;
        bx_d      = 14'd0;
        ly_d      = 13'd0;
        cfg_err_d = 1'b0;
      end else begin
        cfg_err_d = 1'b1;
      end
    end
  end

  always_comb begin
    px    = 13'(bx_q[13:1]) - HStart;
    py    = ly_q - VStart;
    bar_w = (h_act_q[12:3] == 10'd0) ? 13'd1 : {3'b000, h_act_q[12:3]};
  end

  dvp_tx_pattern_gen u_pattern_gen (
    .x         (px),
    .y         (py),
    .pattern   (pat_q),
    .solid_rgb (solid_q),
    .bar_width (bar_w),
    .pixel     (pix)
  );

  always_comb begin
    pix_out = pix;
`ifdef DVP_TX_FRAME_TAG_EN
    if (px == 13'd0 && py == 13'd0) begin
      pix_out = frame_cnt_q;
    end
`endif
    href_d  = (state_q == StActive) && (bx_q >= HrefLo) && (bx_q < HrefLo + {h_act_q, 1'b0});
    vsync_d = state_q == StSync;
    data_d  = href_d ? (bx_q[0] ? pix_out[7:0] : pix_out[15:8]) : 8'h00;
    done_d  = (state_q != StIdle) && frame_end;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bx_q        <= '0;
      ly_q        <= '0;
      frame_cnt_q <= '0;
      cfg_err_q   <= 1'b0;
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      data_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bx_q        <= bx_d;
      ly_q        <= ly_d;
      frame_cnt_q <= frame_cnt_d;
      cfg_err_q   <= cfg_err_d;
      vsync_q     <= vsync_d;
      href_q      <= href_d;
      data_q      <= data_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_act_q <= '0;
      v_act_q <= '0;
      h_tot_q <= '0;
      v_tot_q <= '0;
      pat_q   <= '0;
      solid_q <= '0;
    end else if (latch) begin
      h_act_q <= cmos_h_pixel;
      v_act_q <= cmos_v_pixel;
      h_tot_q <= total_h_pixel;
      v_tot_q <= total_v_pixel;
      pat_q   <= pattern_sel;
      solid_q <= solid_rgb;
    end
  end

  assign cam_vsync  = vsync_q;
  assign cam_href   = href_q;
  assign cam_data   = data_q;
  assign frame_done = done_q;
  assign frame_cnt  = frame_cnt_q;
  assign busy       = state_q != StIdle;
  assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_dvp_cam_tx.sv
// Randomised bench for dvp_cam_tx against a frame-position reference model.
module tb_dvp_cam_tx;

  localparam int VS = 1;
  localparam int VST = 2;
  localparam int HST = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_en;
  logic [1:0]  pattern_sel;
  logic [15:0] solid_rgb;
  logic [12:0] cmos_h_pixel, cmos_v_pixel, total_h_pixel, total_v_pixel;
  logic        cam_vsync, cam_href, frame_done, busy, cfg_err;
  logic [7:0]  cam_data;
  logic [15:0] frame_cnt;

  dvp_cam_tx #(
    .VS_LINES (VS),
    .V_START  (VST),
    .H_START  (HST)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tx_en         (tx_en),
    .pattern_sel   (pattern_sel),
    .solid_rgb     (solid_rgb),
    .cmos_h_pixel  (cmos_h_pixel),
    .cmos_v_pixel  (cmos_v_pixel),
    .total_h_pixel (total_h_pixel),
    .total_v_pixel (total_v_pixel),
    .cam_vsync     (cam_vsync),
    .cam_href      (cam_href),
    .cam_data      (cam_data),
    .frame_done    (frame_done),
    .frame_cnt     (frame_cnt),
    .busy          (busy),
    .cfg_err       (cfg_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: a running frame is just a byte position within 2*htot*vtot.
  bit          m_run, m_err;
  int          m_pos, m_hact, m_vact, m_htot, m_vtot, m_pat;
  logic [15:0] m_solid, m_cnt;
  bit          e_vs, e_hr, e_done;
  logic [7:0]  e_data;
  int          vs_seen, hr_seen, done_seen;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_pixel(input int x, input int y);
    int bw, idx;
    logic [15:0] p;
`ifdef DVP_TX_FRAME_TAG_EN
    if (x == 0 && y == 0) return m_cnt;
`endif
    case (m_pat)
      0: begin
        bw = m_hact / 8;
        if (bw == 0) bw = 1;
        idx = x / bw;
        if (idx > 7) idx = 7;
        case (idx)
          0: p = 16'hFFFF;
          1: p = 16'hFFE0;
          2: p = 16'h07FF;
          3: p = 16'h07E0;
          4: p = 16'hF81F;
          5: p = 16'hF800;
          6: p = 16'h001F;
          default: p = 16'h0000;
        endcase
      end
      1: p = 16'(((y % 256) * 256) + (x % 256));
      2: p = m_solid;
      default: p = ((((x / 8) ^ (y / 8)) % 2) == 1) ? 16'hFFFF : 16'h0000;
    endcase
    return p;
  endfunction

  task automatic model_reset();
    m_run = 0; m_err = 0; m_pos = 0; m_cnt = '0;
    m_hact = 0; m_vact = 0; m_htot = 0; m_vtot = 0; m_pat = 0; m_solid = '0;
    e_vs = 0; e_hr = 0; e_done = 0; e_data = '0;
  endtask

  task automatic model_step();
    int line, bxx, lw;
    bit start;
    logic [15:0] p;
    e_vs = 0; e_hr = 0; e_done = 0; e_data = '0; start = 0;
    if (m_run) begin
      lw   = 2 * m_htot;
      line = m_pos / lw;
      bxx  = m_pos % lw;
      e_vs = line < VS;
      if (line >= VST && line < VST + m_vact && bxx >= 2 * HST && bxx < 2 * (HST + m_hact)) begin
        e_hr   = 1;
        p      = model_pixel(bxx / 2 - HST, line - VST);
        e_data = (bxx % 2 == 0) ? p[15:8] : p[7:0];
      end
      if (m_pos == lw * m_vtot - 1) begin
        e_done = 1;
        m_cnt++;
        m_run = 0;
        start = tx_en;
      end else begin
        m_pos++;
      end
    end else begin
      start = tx_en;
    end
    if (start) begin
      if (int'(cmos_h_pixel) >= 1 && int'(cmos_v_pixel) >= 1 &&
          int'(total_h_pixel) >= HST + int'(cmos_h_pixel) &&
          int'(total_v_pixel) >= VST + int'(cmos_v_pixel)) begin
        m_hact = cmos_h_pixel; m_vact = cmos_v_pixel;
        m_htot = total_h_pixel; m_vtot = total_v_pixel;
        m_pat = pattern_sel; m_solid = solid_rgb;
        m_pos = 0; m_run = 1; m_err = 0;
      end else begin
        m_err = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_eq("vsync", 32'(cam_vsync), 32'(e_vs));
    check_eq("href", 32'(cam_href), 32'(e_hr));
    check_eq("data", 32'(cam_data), 32'(e_data));
    check_eq("frame_done", 32'(frame_done), 32'(e_done));
    check_eq("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
    check_eq("busy", 32'(busy), 32'(m_run));
    check_eq("cfg_err", 32'(cfg_err), 32'(m_err));
    vs_seen   += int'(cam_vsync);
    hr_seen   += int'(cam_href);
    done_seen += int'(frame_done);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_cfg(input int ha, input int va, input int ht, input int vt);
    cmos_h_pixel = 13'(ha); cmos_v_pixel = 13'(va);
    total_h_pixel = 13'(ht); total_v_pixel = 13'(vt);
  endtask

  task automatic rand_cfg();
    int h, v;
    h = $urandom_range(1, 20);
    v = $urandom_range(1, 4);
    set_cfg(h, v, HST + h + $urandom_range(0, 3), VST + v + $urandom_range(0, 2));
    case ($urandom_range(0, 9))
      0: total_h_pixel = 13'(HST + h - 1);
      1: cmos_v_pixel = 13'd0;
      2: total_v_pixel = 13'(VST + v - 1);
      default: ;
    endcase
    pattern_sel = 2'($urandom_range(0, 3));
    solid_rgb   = 16'($urandom);
  endtask

  initial begin
    bit found;
    tx_en = 1'b1;
    pattern_sel = 2'd0;
    solid_rgb = 16'h1234;
    set_cfg(8, 2, 12, 6);
    model_reset();
    vs_seen = 0; hr_seen = 0; done_seen = 0;
    #12;
    check_eq("rst_vsync", 32'(cam_vsync), 32'd0);
    check_eq("rst_href", 32'(cam_href), 32'd0);
    check_eq("rst_data", 32'(cam_data), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check_eq("rst_cfg_err", 32'(cfg_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Three default colour-bar frames back to back.
    run(1 + 3 * 144);
    check_eq("vsync_cycles", 32'(vs_seen), 32'd72);
    check_eq("href_cycles", 32'(hr_seen), 32'd96);
    check_eq("done_pulses", 32'(done_seen), 32'd3);

    pattern_sel = 2'd1;
    run(144);
    pattern_sel = 2'd2;
    solid_rgb = 16'h1234;
    run(144);
    pattern_sel = 2'd3;
    set_cfg(16, 2, 20, 6);
    run(240);
    set_cfg(8, 2, 8, 6);      // rejected at the next restart
    run(300);
    set_cfg(8, 2, 12, 6);
    run(200);
    run(50);
    tx_en = 1'b0;             // current frame must still complete
    run(250);

    // Asynchronous reset in the middle of an active line.
    tx_en = 1'b1;
    pattern_sel = 2'd0;
    found = 0;
    for (int i = 0; i < 500 && !found; i++) begin
      tick();
      found = e_hr;
    end
    check_eq("href_wait", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_vsync", 32'(cam_vsync), 32'd0);
    check_eq("arst_href", 32'(cam_href), 32'd0);
    check_eq("arst_data", 32'(cam_data), 32'd0);
    check_eq("arst_frame_cnt", 32'(frame_cnt), 32'd0);
    check_eq("arst_busy", 32'(busy), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run(300);

    // Randomised configuration, pattern and enable traffic.
    for (int seg = 0; seg < 30; seg++) begin
      rand_cfg();
      tx_en = 1'b1;
      for (int c = 0; c < 250; c++) begin
        if ($urandom_range(0, 99) < 2) tx_en = ~tx_en;
        if ($urandom_range(0, 99) < 1) rand_cfg();
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
